// File: rtl/asym_fifo_ctrl_pkg.sv
// Shared types, defaults and elaboration helpers for the asymmetric FIFO controller.
package asym_fifo_ctrl_pkg;

   localparam int unsigned DEF_RAM_DEPTH      = 32;
   localparam int unsigned DEF_RAM_ADDR_WIDTH = 5;
   localparam int unsigned DEF_WR_WIDTH       = 8;
   localparam int unsigned DEF_RD_WIDTH       = 32;
   localparam int unsigned DEF_WR_IND         = 1;
   localparam int unsigned DEF_RD_IND         = 4;
   localparam int unsigned DEF_AFULL_THR      = 28;
   localparam int unsigned DEF_AEMPTY_THR     = 4;

   // Ceiling log2, used only at elaboration time.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrapping RAM address pointer advancing by STEP units per accepted access.
module fifo_ptr_cnt #(
   parameter int unsigned STEP  = 1,
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] ptr
);

   logic [WIDTH-1:0] r_ptr;

   // Natural wrap at 2**WIDTH gives modulo-depth addressing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (clr)
         r_ptr <= '0;
      else if (inc)
         r_ptr <= r_ptr + WIDTH'(STEP);
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Pointer, occupancy and flag controller sequencing an asymmetric-width RAM as a FIFO.
module asym_fifo_ctrl
   import asym_fifo_ctrl_pkg::*;
#(
   parameter int unsigned RAM_DEPTH      = DEF_RAM_DEPTH,
   parameter int unsigned RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
   parameter int unsigned WR_WIDTH       = DEF_WR_WIDTH,
   parameter int unsigned RD_WIDTH       = DEF_RD_WIDTH,
   parameter int unsigned WR_IND         = DEF_WR_IND,
   parameter int unsigned RD_IND         = DEF_RD_IND,
   parameter int unsigned AFULL_THR      = DEF_AFULL_THR,
   parameter int unsigned AEMPTY_THR     = DEF_AEMPTY_THR
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic                      rd_en,
   output logic                      ram_wr_en,
   output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [RAM_ADDR_WIDTH:0]   count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned CW        = RAM_ADDR_WIDTH + 1;
   localparam int unsigned RAM_WIDTH = min_u(WR_WIDTH, RD_WIDTH);

   // Elaboration-time legality of the geometry.
   if (!is_pow2(RAM_DEPTH)) begin : g_err_depth_pow2
      $error("RAM_DEPTH must be a power of 2");
   end
   if (clog2(RAM_DEPTH) != RAM_ADDR_WIDTH) begin : g_err_addr_width
      $error("RAM_ADDR_WIDTH must equal log2(RAM_DEPTH)");
   end
   if ((RAM_DEPTH % WR_IND != 0) || (RAM_DEPTH % RD_IND != 0)) begin : g_err_divisible
      $error("RAM_DEPTH must be a multiple of WR_IND and RD_IND");
   end
   if ((WR_IND * RAM_WIDTH != WR_WIDTH) || (RD_IND * RAM_WIDTH != RD_WIDTH)) begin : g_err_ratio
      $error("WR_IND/RD_IND must match the width ratios");
   end

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_full;
   logic          r_empty;
   logic          r_afull;
   logic          r_aempty;
   logic          r_rd_valid;
   logic          r_overflow;
   logic          r_underflow;
   logic          w_wr_acc;
   logic          w_rd_acc;
   logic          w_wr_refused;
   logic          w_rd_refused;

   // Flags are pre-edge state; clr overrides both requests.
   assign w_wr_acc     = wr_en & ~r_full  & ~clr;
   assign w_rd_acc     = rd_en & ~r_empty & ~clr;
   assign w_wr_refused = wr_en &  r_full  & ~clr;
   assign w_rd_refused = rd_en &  r_empty & ~clr;

   always_comb begin
      w_count_nxt = r_count;
      if (clr) begin
         w_count_nxt = '0;
      end else begin
         if (w_wr_acc) w_count_nxt = w_count_nxt + CW'(WR_IND);
         if (w_rd_acc) w_count_nxt = w_count_nxt - CW'(RD_IND);
      end
   end

   // Flags are registered from the next count so they track the count register exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_rd_valid  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_full      <= w_count_nxt >  CW'(RAM_DEPTH - WR_IND);
         r_empty     <= w_count_nxt <  CW'(RD_IND);
         r_afull     <= w_count_nxt >= CW'(AFULL_THR);
         r_aempty    <= w_count_nxt <= CW'(AEMPTY_THR);
         r_rd_valid  <= w_rd_acc;
         r_overflow  <= w_wr_refused;
         r_underflow <= w_rd_refused;
      end
   end

   fifo_ptr_cnt #(
      .STEP  (WR_IND),
      .WIDTH (RAM_ADDR_WIDTH)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (w_wr_acc),
      .ptr   (ram_wr_addr)
   );

   fifo_ptr_cnt #(
      .STEP  (RD_IND),
      .WIDTH (RAM_ADDR_WIDTH)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (w_rd_acc),
      .ptr   (ram_rd_addr)
   );

   assign ram_wr_en    = w_wr_acc;
   assign rd_valid     = r_rd_valid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// Self-checking bench: controller plus a byte-write / word-read RAM model on one clock.
module tb_asym_fifo_ctrl;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned WIND  = 1;
   localparam int unsigned RIND  = 4;
   localparam int unsigned AFT   = 28;
   localparam int unsigned AET   = 4;

   logic          clk;
   logic          rst_n;
   logic          clr;
   logic          wr_en;
   logic          rd_en;
   logic [7:0]    wr_data;
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [AW-1:0] ram_rd_addr;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;
   logic [31:0]   rd_data;
   logic [7:0]    mem [0:DEPTH-1];

   int    checks;
   int    errors;
   string phase;

   // Reference model: stored bytes in order, plus plain integer pointers.
   logic [7:0]  mq [$];
   int          m_wptr;
   int          m_rptr;
   logic        m_rv;
   logic        m_ovf;
   logic        m_unf;
   logic [31:0] m_word;

   typedef struct {
      logic        c;
      logic        w;
      logic        r;
      logic [7:0]  d;
      int          e_count;
      logic        e_empty;
      logic        e_rv;
      logic        e_unf;
      int          e_waddr;
      int          e_raddr;
      logic [31:0] e_word;
   } vec_t;

   vec_t tbl [7];

   asym_fifo_ctrl #(
      .RAM_DEPTH      (DEPTH),
      .RAM_ADDR_WIDTH (AW),
      .WR_WIDTH       (8),
      .RD_WIDTH       (32),
      .WR_IND         (WIND),
      .RD_IND         (RIND),
      .AFULL_THR      (AFT),
      .AEMPTY_THR     (AET)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .ram_wr_en    (ram_wr_en),
      .ram_wr_addr  (ram_wr_addr),
      .ram_rd_addr  (ram_rd_addr),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asymmetric RAM: byte writes, little-endian 32-bit registered reads.
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
      rd_data <= {mem[{ram_rd_addr[AW-1:2], 2'd3}], mem[{ram_rd_addr[AW-1:2], 2'd2}],
                  mem[{ram_rd_addr[AW-1:2], 2'd1}], mem[{ram_rd_addr[AW-1:2], 2'd0}]};
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL [%s] %s: got %0h expected %0h at %0t", phase, nm, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [7:0] d,
                               input int ec, input logic ee, input logic erv, input logic eu,
                               input int ewa, input int era, input logic [31:0] ewd);
      vec_t v;
      v.c = c; v.w = w; v.r = r; v.d = d;
      v.e_count = ec; v.e_empty = ee; v.e_rv = erv; v.e_unf = eu;
      v.e_waddr = ewa; v.e_raddr = era; v.e_word = ewd;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_wptr = 0; m_rptr = 0;
      m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_word = '0;
   endtask

   task automatic check_state();
      int n;
      n = mq.size();
      chk("count",        32'(count),        32'(n));
      chk("full",         32'(full),         32'(n > int'(DEPTH - WIND)));
      chk("empty",        32'(empty),        32'(n < int'(RIND)));
      chk("almost_full",  32'(almost_full),  32'(n >= int'(AFT)));
      chk("almost_empty", 32'(almost_empty), 32'(n <= int'(AET)));
      chk("rd_valid",     32'(rd_valid),     32'(m_rv));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
      chk("ram_wr_addr",  32'(ram_wr_addr),  32'(m_wptr));
      chk("ram_rd_addr",  32'(ram_rd_addr),  32'(m_rptr));
      if (m_rv) chk("rd_data", rd_data, m_word);
   endtask

   // One clock of stimulus; called and returns at posedge+1.
   task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
      logic pf, pe, wa, ra;
      pf = mq.size() > int'(DEPTH - WIND);
      pe = mq.size() < int'(RIND);
      wa = w & ~pf & ~c;
      ra = r & ~pe & ~c;
      clr = c; wr_en = w; rd_en = r; wr_data = d;
      #1;
      chk("ram_wr_en", 32'(ram_wr_en), 32'(wa));
      @(posedge clk);
      #1;
      if (c) begin
         model_reset();
      end else begin
         m_rv  = ra;
         m_ovf = w & pf;
         m_unf = r & pe;
         if (ra) begin
            for (int k = 0; k < 4; k++) m_word[8*k +: 8] = mq.pop_front();
            m_rptr = (m_rptr + int'(RIND)) % int'(DEPTH);
         end
         if (wa) begin
            mq.push_back(d);
            m_wptr = (m_wptr + int'(WIND)) % int'(DEPTH);
         end
      end
      clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      check_state();
   endtask

   // Asynchronous reset asserted mid-cycle and checked before any edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst rd_valid",     32'(rd_valid),     32'd0);
      chk("rst count",        32'(count),        32'd0);
      chk("rst empty",        32'(empty),        32'd1);
      chk("rst almost_empty", 32'(almost_empty), 32'd1);
      chk("rst full",         32'(full),         32'd0);
      chk("rst ram_wr_addr",  32'(ram_wr_addr),  32'd0);
      chk("rst ram_rd_addr",  32'(ram_rd_addr),  32'd0);
      chk("rst overflow",     32'(overflow),     32'd0);
      chk("rst underflow",    32'(underflow),    32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      checks = 0; errors = 0;
      rst_n = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      model_reset();

      tbl[0] = mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 1, 0, 32'h0);
      tbl[1] = mk(0, 1, 0, 8'h01, 2, 1, 0, 0, 2, 0, 32'h0);
      tbl[2] = mk(0, 1, 0, 8'h02, 3, 1, 0, 0, 3, 0, 32'h0);
      tbl[3] = mk(0, 1, 0, 8'h03, 4, 0, 0, 0, 4, 0, 32'h0);
      tbl[4] = mk(0, 0, 1, 8'h00, 0, 1, 1, 0, 4, 4, 32'h03020100);
      tbl[5] = mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 4, 4, 32'h0);
      tbl[6] = mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 4, 4, 32'h0);

      @(posedge clk); #1;
      phase = "reset";
      do_reset();

      phase = "table";
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
         chk("tbl count",    32'(count),       32'(tbl[i].e_count));
         chk("tbl empty",    32'(empty),       32'(tbl[i].e_empty));
         chk("tbl rd_valid", 32'(rd_valid),    32'(tbl[i].e_rv));
         chk("tbl underflow",32'(underflow),   32'(tbl[i].e_unf));
         chk("tbl wr_addr",  32'(ram_wr_addr), 32'(tbl[i].e_waddr));
         chk("tbl rd_addr",  32'(ram_rd_addr), 32'(tbl[i].e_raddr));
         if (tbl[i].e_rv) chk("tbl rd_data", rd_data, tbl[i].e_word);
      end

      phase = "reset_after_read";
      for (int i = 4; i < 8; i++) step(0, 1, 0, 8'(i));
      step(0, 0, 1, 8'h00);
      chk("rd_valid before reset", 32'(rd_valid), 32'd1);
      do_reset();

      phase = "fill";
      for (int i = 0; i < 32; i++) step(0, 1, 0, 8'(8'h40 + i));
      chk("fill full",  32'(full),  32'd1);
      chk("fill count", 32'(count), 32'd32);
      step(0, 1, 0, 8'hAA);
      chk("ovf pulse",   32'(overflow),    32'd1);
      chk("ovf count",   32'(count),       32'd32);
      chk("ovf wr_addr", 32'(ram_wr_addr), 32'd0);
      step(0, 0, 0, 8'h00);
      chk("ovf pulse end", 32'(overflow), 32'd0);

      phase = "simultaneous";
      for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h00);
      chk("pre-sim count", 32'(count), 32'd8);
      step(0, 1, 1, 8'h55);
      chk("sim count",    32'(count),       32'd5);
      chk("sim wr_addr",  32'(ram_wr_addr), 32'd1);
      chk("sim rd_addr",  32'(ram_rd_addr), 32'd28);
      chk("sim rd_valid", 32'(rd_valid),    32'd1);

      phase = "clr";
      for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h60 + i));
      chk("pre-clr count", 32'(count), 32'd12);
      step(1, 1, 0, 8'h77);
      chk("clr count",   32'(count),       32'd0);
      chk("clr empty",   32'(empty),       32'd1);
      chk("clr wr_addr", 32'(ram_wr_addr), 32'd0);

      phase = "wrap";
      b = 8'h80;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            step(0, 1, 0, b);
            b = b + 8'd1;
         end
         step(0, 0, 1, 8'h00);
      end
      chk("wrap wr_addr", 32'(ram_wr_addr), 32'd8);
      chk("wrap rd_addr", 32'(ram_rd_addr), 32'd8);
      step(0, 0, 1, 8'h00);
      chk("empty read underflow", 32'(underflow), 32'd1);
      chk("empty read rd_valid",  32'(rd_valid),  32'd0);

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
              8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
